// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: FSM states, count width,
// default timeout and the saturating increment used by the cycle counters.
package period_meter_pkg;

  localparam int          CNT_W           = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 100_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  // Counting past all-ones would report a tiny period for a stuck input, so hold at max.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Brings the asynchronous input into the clk domain and turns its level
// changes into single-cycle rise/fall pulses.
module sync_edge_det
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= synced;
    end
  end

  // Pulses are combinational off the last two flops, so the FSM acts on an
  // input change on the SYNC_STAGES+1-th clock edge after it.
  assign rise = synced & ~prev_q;
  assign fall = ~synced & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures one full period and the high time of a slow asynchronous square wave,
// counted in clk cycles between synchronized edge pulses, with a start-to-done timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic rise;
  logic fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             closing;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      edge_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      high_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt_q  <= edge_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      high_q      <= high_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    high_d      = high_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    closing     = 1'b0;

    // The rise cycle is index 0, so each latched result is the counter plus one.
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ARM;
          busy_d    = 1'b1;
          tmo_cnt_d = '0;
        end
      end
      ARM: begin
        if (rise) begin
          state_d    = HIGH;
          edge_cnt_d = '0;
        end
      end
      HIGH: begin
        edge_cnt_d = sat_inc(edge_cnt_q);
        if (fall) begin
          high_d  = sat_inc(edge_cnt_q);
          state_d = LOW;
        end
      end
      LOW: begin
        edge_cnt_d = sat_inc(edge_cnt_q);
        if (rise) begin
          period_d    = sat_inc(edge_cnt_q);
          high_time_d = high_q;
          closing     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A closing rise on the last allowed cycle still counts as a completed measurement.
    if (state_q != IDLE) begin
      if (closing) begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else if (tmo_cnt_q == TMO_LAST) begin
        timeout_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  assign busy      = busy_q;
  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Scenario bench for period_meter: each test builds a per-cycle stimulus table,
// predicts results from an edge-event model of the square wave, and compares.
module tb_period_meter;

  localparam int TMO  = 64;
  localparam int SS   = 2;
  localparam int MAXL = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        start;
  logic        busy;
  logic        valid;
  logic        timeout;
  logic [31:0] period;
  logic [31:0] high_time;

  period_meter #(
    .TIMEOUT    (TMO),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .start    (start),
    .busy     (busy),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus table: index k is driven just before clock edge k.
  logic w  [MAXL];
  logic st [MAXL];
  logic rs [MAXL];

  // Observed and expected outputs right after clock edge k.
  logic        ob_valid [MAXL];
  logic        ob_tmo   [MAXL];
  logic        ob_busy  [MAXL];
  logic [31:0] ob_per   [MAXL];
  logic [31:0] ob_high  [MAXL];
  logic        ex_valid [MAXL];
  logic        ex_tmo   [MAXL];
  logic        ex_busy  [MAXL];
  logic [31:0] ex_per   [MAXL];
  logic [31:0] ex_high  [MAXL];

  logic [31:0] m_per  = '0;
  logic [31:0] m_high = '0;

  task automatic clear_stim();
    for (int k = 0; k < MAXL; k++) begin
      w[k]  = 1'b0;
      st[k] = 1'b0;
      rs[k] = 1'b0;
    end
  endtask

  task automatic make_wave(input int first, input int hi, input int lo, input int len);
    for (int k = 0; k < len; k++)
      w[k] = (k >= first) && (((k - first) % (hi + lo)) < hi);
  endtask

  task automatic put_level(input int from, input int upto, input logic lvl);
    for (int k = from; k < upto; k++) w[k] = lvl;
  endtask

  // Holds w[0] long enough that no edge from earlier activity is still in flight.
  task automatic run_scenario(input int len);
    for (int p = 0; p < SS + 2; p++) begin
      @(negedge clk);
      sig_in = w[0];
      start  = 1'b0;
      rst    = 1'b0;
    end
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      if (k > 0) begin
        ob_valid[k-1] = valid;
        ob_tmo[k-1]   = timeout;
        ob_busy[k-1]  = busy;
        ob_per[k-1]   = period;
        ob_high[k-1]  = high_time;
      end
      if (k < len) begin
        sig_in = w[k];
        start  = st[k];
        rst    = rs[k];
      end else begin
        start = 1'b0;
        rst   = 1'b0;
      end
    end
  endtask

  function automatic logic level_at(input int j);
    return (j < 0) ? w[0] : w[j];
  endfunction

  // An input change first sampled at edge j is seen by the meter at edge j+SS.
  function automatic int next_edge(input int from, input logic lvl, input int len);
    int found = -1;
    for (int i = from + 1; i < len; i++)
      if (found < 0 && i - SS >= 0 && level_at(i - SS) == lvl && level_at(i - SS - 1) != lvl)
        found = i;
    return found;
  endfunction

  task automatic build_model(input int len);
    int          idx, a, r1, f, r2, fin, rr;
    logic [31:0] cur_p, cur_h;
    logic        done_at [MAXL];
    logic [31:0] res_p   [MAXL];
    logic [31:0] res_h   [MAXL];
    for (int k = 0; k < MAXL; k++) begin
      ex_valid[k] = 1'b0;
      ex_tmo[k]   = 1'b0;
      ex_busy[k]  = 1'b0;
      done_at[k]  = 1'b0;
      res_p[k]    = '0;
      res_h[k]    = '0;
    end
    idx = 0;
    while (idx < len) begin
      a = -1;
      for (int k = idx; k < len; k++) if (a < 0 && st[k] && !rs[k]) a = k;
      if (a < 0) break;
      r1  = next_edge(a, 1'b1, len);
      f   = (r1 >= 0) ? next_edge(r1, 1'b0, len) : -1;
      r2  = (f >= 0) ? next_edge(f, 1'b1, len) : -1;
      fin = (r2 >= 0 && r2 - a <= TMO) ? r2 : a + TMO;
      rr  = -1;
      for (int k = a + 1; k <= fin && k < len; k++) if (rr < 0 && rs[k]) rr = k;
      if (rr >= 0) fin = rr;
      for (int k = a; k < fin && k < len; k++) ex_busy[k] = 1'b1;
      if (rr < 0 && fin < len) begin
        if (fin == r2) begin
          ex_valid[fin] = 1'b1;
          done_at[fin]  = 1'b1;
          res_p[fin]    = 32'(r2 - r1);
          res_h[fin]    = 32'(f - r1);
        end else begin
          ex_tmo[fin] = 1'b1;
        end
      end
      idx = fin + 1;
    end
    cur_p = m_per;
    cur_h = m_high;
    for (int k = 0; k < len; k++) begin
      if (rs[k]) begin
        cur_p = '0;
        cur_h = '0;
      end else if (done_at[k]) begin
        cur_p = res_p[k];
        cur_h = res_h[k];
      end
      ex_per[k]  = cur_p;
      ex_high[k] = cur_h;
    end
  endtask

  task automatic commit_model(input int len);
    m_per  = ex_per[len-1];
    m_high = ex_high[len-1];
  endtask

  function automatic int pulse_count(input logic use_tmo, input int len);
    int n = 0;
    for (int k = 0; k < len; k++) if (use_tmo ? ob_tmo[k] : ob_valid[k]) n++;
    return n;
  endfunction

  function automatic int pulse_first(input logic use_tmo, input int len);
    int n = -1;
    for (int k = 0; k < len; k++) if (n < 0 && (use_tmo ? ob_tmo[k] : ob_valid[k])) n = k;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got busy=%b valid=%b timeout=%b, want 0 0 0", busy, valid, timeout);
    end
    vectors++;
    if (period !== 32'd0 || high_time !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_results: got period=%0d high=%0d, want 0 0", period, high_time);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0 || period !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got busy=%b valid=%b timeout=%b period=%0d, want 0 0 0 0",
               busy, valid, timeout, period);
    end
    m_per  = '0;
    m_high = '0;
  endtask

  task automatic test_basic();
    int len = 40;
    int idx;
    clear_stim();
    make_wave(3, 4, 6, len);
    st[0] = 1'b1;
    build_model(len);
    run_scenario(len);
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
          ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
        miscompares++;
        $display("[TB] FAIL basic cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                 k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                 ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
      end
    end
    vectors++;
    if (pulse_count(1'b0, len) !== 1) begin
      miscompares++;
      $display("[TB] FAIL basic_valid_count: got %0d, want 1", pulse_count(1'b0, len));
    end
    idx = pulse_first(1'b0, len);
    vectors++;
    if (idx <= 0 || ob_per[idx] !== 32'd10 || ob_high[idx] !== 32'd4 || ob_busy[idx] !== 1'b0 ||
        ob_busy[idx-1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_result: got valid at %0d, want period=10 high=4 with busy falling", idx);
    end
    commit_model(len);
  endtask

  task automatic test_timeout();
    int          len = 72;
    logic [31:0] prev_p, prev_h;
    clear_stim();
    st[0]  = 1'b1;
    prev_p = m_per;
    prev_h = m_high;
    build_model(len);
    run_scenario(len);
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
          ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
        miscompares++;
        $display("[TB] FAIL timeout cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                 k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                 ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
      end
    end
    vectors++;
    if (pulse_first(1'b1, len) !== TMO || pulse_count(1'b1, len) !== 1) begin
      miscompares++;
      $display("[TB] FAIL timeout_position: got first at %0d count %0d, want at %0d count 1",
               pulse_first(1'b1, len), pulse_count(1'b1, len), TMO);
    end
    vectors++;
    if (ob_per[len-1] !== prev_p || ob_high[len-1] !== prev_h || ob_busy[len-1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_keeps: got p=%0d h=%0d busy=%b, want p=%0d h=%0d busy=0",
               ob_per[len-1], ob_high[len-1], ob_busy[len-1], prev_p, prev_h);
    end
    commit_model(len);
  endtask

  task automatic test_busy_start();
    int len = 80;
    int e1  = -1;
    clear_stim();
    make_wave(3, 5, 5, len);
    st[0] = 1'b1;
    build_model(len);
    for (int k = 0; k < len; k++) if (e1 < 0 && ex_valid[k]) e1 = k;
    if (e1 < 0) e1 = 15;
    st[10]   = 1'b1;
    st[e1]   = 1'b1;
    st[e1+1] = 1'b1;
    build_model(len);
    run_scenario(len);
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
          ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
        miscompares++;
        $display("[TB] FAIL busy_start cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                 k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                 ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
      end
    end
    vectors++;
    if (pulse_count(1'b0, len) !== 2 || ob_per[len-1] !== 32'd10 || ob_high[len-1] !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: got %0d valids p=%0d h=%0d, want 2 valids p=10 h=5",
               pulse_count(1'b0, len), ob_per[len-1], ob_high[len-1]);
    end
    commit_model(len);
  endtask

  task automatic test_reset_mid();
    int len = 60;
    int bad = 0;
    clear_stim();
    make_wave(16, 3, 3, len);
    put_level(3, 7, 1'b1);
    st[0]  = 1'b1;
    rs[12] = 1'b1;
    st[14] = 1'b1;
    build_model(len);
    run_scenario(len);
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
          ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
        miscompares++;
        $display("[TB] FAIL reset_mid cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                 k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                 ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
      end
    end
    for (int k = 0; k <= 13; k++) if (ob_valid[k] || ob_tmo[k]) bad++;
    vectors++;
    if (bad !== 0 || ob_per[12] !== 32'd0 || ob_high[12] !== 32'd0 || ob_busy[12] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_abort: got %0d pulses, p=%0d h=%0d busy=%b, want 0 pulses and zeros",
               bad, ob_per[12], ob_high[12], ob_busy[12]);
    end
    vectors++;
    if (ob_per[len-1] !== 32'd6 || ob_high[len-1] !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL reset_fresh: got p=%0d h=%0d, want p=6 h=3", ob_per[len-1], ob_high[len-1]);
    end
    commit_model(len);
  endtask

  task automatic test_coincide();
    int len = 75;
    // Closing rise lands on the final allowed cycle.
    clear_stim();
    put_level(5, 9, 1'b1);
    put_level(62, len, 1'b1);
    st[0] = 1'b1;
    build_model(len);
    run_scenario(len);
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
          ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
        miscompares++;
        $display("[TB] FAIL coincide cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                 k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                 ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
      end
    end
    vectors++;
    if (pulse_count(1'b0, len) !== 1 || pulse_count(1'b1, len) !== 0 || ob_per[len-1] !== 32'd57) begin
      miscompares++;
      $display("[TB] FAIL coincide_wins: got %0d valid %0d timeout p=%0d, want 1 valid 0 timeout p=57",
               pulse_count(1'b0, len), pulse_count(1'b1, len), ob_per[len-1]);
    end
    commit_model(len);
    // One cycle later the timeout must win instead.
    clear_stim();
    put_level(5, 9, 1'b1);
    put_level(63, len, 1'b1);
    st[0] = 1'b1;
    build_model(len);
    run_scenario(len);
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
          ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
        miscompares++;
        $display("[TB] FAIL late_close cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                 k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                 ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
      end
    end
    vectors++;
    if (pulse_count(1'b0, len) !== 0 || pulse_first(1'b1, len) !== TMO) begin
      miscompares++;
      $display("[TB] FAIL late_close_timeout: got %0d valid, timeout at %0d, want 0 valid, timeout at %0d",
               pulse_count(1'b0, len), pulse_first(1'b1, len), TMO);
    end
    commit_model(len);
  endtask

  task automatic test_start_high();
    int len = 50;
    clear_stim();
    make_wave(10, 4, 6, len);
    put_level(0, 6, 1'b1);
    st[0] = 1'b1;
    build_model(len);
    run_scenario(len);
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
          ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
        miscompares++;
        $display("[TB] FAIL start_high cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                 k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                 ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
      end
    end
    vectors++;
    if (pulse_count(1'b0, len) !== 1 || ob_per[len-1] !== 32'd10 || ob_high[len-1] !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL start_high_skip: got %0d valids p=%0d h=%0d, want 1 valid p=10 h=4",
               pulse_count(1'b0, len), ob_per[len-1], ob_high[len-1]);
    end
    commit_model(len);
  endtask

  task automatic test_random();
    int hi, lo, first, s0, len;
    for (int it = 0; it < 10; it++) begin
      hi    = int'($urandom_range(12, 1));
      lo    = int'($urandom_range(12, 1));
      first = int'($urandom_range(20, 1));
      s0    = int'($urandom_range(15, 0));
      len   = s0 + TMO + 6;
      clear_stim();
      make_wave(first, hi, lo, len);
      st[s0] = 1'b1;
      build_model(len);
      run_scenario(len);
      for (int k = 0; k < len; k++) begin
        vectors++;
        if (ob_valid[k] !== ex_valid[k] || ob_tmo[k] !== ex_tmo[k] || ob_busy[k] !== ex_busy[k] ||
            ob_per[k] !== ex_per[k] || ob_high[k] !== ex_high[k]) begin
          miscompares++;
          $display("[TB] FAIL random%0d (hi=%0d lo=%0d) cycle %0d: got v=%b t=%b b=%b p=%0d h=%0d, want v=%b t=%b b=%b p=%0d h=%0d",
                   it, hi, lo, k, ob_valid[k], ob_tmo[k], ob_busy[k], ob_per[k], ob_high[k],
                   ex_valid[k], ex_tmo[k], ex_busy[k], ex_per[k], ex_high[k]);
        end
      end
      commit_model(len);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    test_coincide();
    test_start_high();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
